// File: rtl/msoc_ocimem_debug_sequencer_if.sv
// OCI debug RAM port between the JTAG debug sequencer (master) and the RAM arbiter (slave).
interface msoc_ocimem_debug_sequencer_if #(
   parameter int ADDR_W = 8
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/msoc_ocimem_debug_sequencer.sv
// Queues JTAG debug memory commands, issues them one at a time on the OCI RAM port and
// returns read data on MonDReg with sticky overflow/timeout status.
module msoc_ocimem_debug_sequencer #(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [37:0]                   jdo,
   input  logic                          take_action_ocimem_a,
   input  logic                          take_action_ocimem_b,
   input  logic                          take_no_action_ocimem_a,
   msoc_ocimem_debug_sequencer_if.master mem,
   output logic [31:0]                   MonDReg,
   output logic                          monitor_ready,
   output logic                          monitor_error,
   output logic [$clog2(FIFO_DEPTH):0]   cmd_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_REQ   = 2'd1;
   localparam logic [1:0] ST_RWAIT = 2'd2;

   localparam logic [7:0]     TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
   } cmd_t;

   cmd_t              fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_idx;
   logic [PTR_W-1:0]  rd_idx;
   logic [PTR_W:0]    count;
   logic [ADDR_W-1:0] pointer;
   logic [ADDR_W-1:0] next_pointer;
   logic [1:0]        state;
   logic [7:0]        timer;

   logic              pop;
   logic              full;
   logic              enq_req;
   logic              push;
   logic              overflow;
   logic              timeout_hit;
   logic              timer_last;
   cmd_t              enq_cmd;
   cmd_t              head;
   logic [ADDR_W-1:0] jdo_addr;
   logic              unused_jdo;

   assign jdo_addr   = jdo[16+ADDR_W:17];
   assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
   assign head       = fifo_mem[rd_idx];
   assign timer_last = (timer == TMO_LAST);

   // Strobe decode with priority a > b > no_action; a full FIFO drops the command
   // unless the sequencer is popping the head in the same cycle.
   always_comb begin
      pop          = (state == ST_IDLE) && (count != '0);
      full         = (count == FULL_CNT);
      enq_req      = 1'b0;
      enq_cmd      = '0;
      next_pointer = pointer;
      if (take_action_ocimem_a) begin
         next_pointer = jdo_addr;
         if (jdo[35]) begin
            enq_req = 1'b1;
            enq_cmd = '{we: 1'b0, addr: jdo_addr, wdata: 32'h0};
         end
      end else if (take_action_ocimem_b) begin
         enq_req = 1'b1;
         enq_cmd = '{we: 1'b1, addr: pointer, wdata: jdo[34:3]};
      end else if (take_no_action_ocimem_a) begin
         enq_req = 1'b1;
         enq_cmd = '{we: 1'b0, addr: pointer, wdata: 32'h0};
      end
      overflow = enq_req && full && !pop;
      push     = enq_req && !overflow;
      if (push) begin
         next_pointer = ADDR_W'(enq_cmd.addr + 1'b1);
      end
   end

   always_comb begin
      timeout_hit = 1'b0;
      if (state == ST_REQ) begin
         timeout_hit = !mem.mem_gnt && timer_last;
      end else if (state == ST_RWAIT) begin
         timeout_hit = !mem.mem_rvalid && timer_last;
      end
   end

   // Entry storage carries no reset; occupancy is governed by the indices below.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_idx] <= enq_cmd;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_idx  <= '0;
         rd_idx  <= '0;
         count   <= '0;
         pointer <= '0;
      end else begin
         pointer <= next_pointer;
         if (push) begin
            wr_idx <= wr_idx + 1'b1;
         end
         if (pop) begin
            rd_idx <= rd_idx + 1'b1;
         end
         count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      end
   end

   // Transfer sequencer: one outstanding command, request held until grant or timeout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         timer         <= '0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         MonDReg       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= head.we;
                  mem.mem_addr  <= head.addr;
                  mem.mem_wdata <= head.wdata;
                  timer         <= '0;
                  state         <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem.mem_gnt) begin
                  mem.mem_req <= 1'b0;
                  timer       <= '0;
                  state       <= mem.mem_we ? ST_IDLE : ST_RWAIT;
               end else if (timer_last) begin
                  mem.mem_req <= 1'b0;
                  state       <= ST_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_RWAIT: begin
               if (mem.mem_rvalid) begin
                  MonDReg <= mem.mem_rdata;
                  state   <= ST_IDLE;
               end else if (timer_last) begin
                  state <= ST_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               mem.mem_req <= 1'b0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

   // A new error in the same cycle wins over the clear from ocimem_a.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         monitor_error <= 1'b0;
      end else if (overflow || timeout_hit) begin
         monitor_error <= 1'b1;
      end else if (take_action_ocimem_a) begin
         monitor_error <= 1'b0;
      end
   end

   assign cmd_count     = count;
   assign monitor_ready = (count == '0) && (state == ST_IDLE);

endmodule

// File: tb/tb_msoc_ocimem_debug_sequencer.sv
// Directed scenarios plus randomized traffic against a queue-based transaction model of the sequencer.
module tb_msoc_ocimem_debug_sequencer;

   localparam int ADDR_W     = 8;
   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT    = 15;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
   } cmd_t;

   logic        clk;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_a;
   logic        take_b;
   logic        take_na;
   logic [31:0] MonDReg;
   logic        monitor_ready;
   logic        monitor_error;
   logic [2:0]  cmd_count;

   msoc_ocimem_debug_sequencer_if #(.ADDR_W(ADDR_W)) memIf ();

   msoc_ocimem_debug_sequencer #(
      .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .jdo(jdo),
      .take_action_ocimem_a(take_a),
      .take_action_ocimem_b(take_b),
      .take_no_action_ocimem_a(take_na),
      .mem(memIf.master),
      .MonDReg(MonDReg),
      .monitor_ready(monitor_ready),
      .monitor_error(monitor_error),
      .cmd_count(cmd_count)
   );

   int checks = 0;
   int errors = 0;

   int          gntMode = 0;
   int          rvMode  = 0;
   logic [31:0] rdataFixed = 32'h0;
   cmd_t        capQ[$];

   cmd_t        mq[$];
   logic [7:0]  mPtr;
   bit          mWaitGnt;
   bit          mWaitData;
   int          mTimer;
   cmd_t        mCur;
   bit          mErr;
   logic [31:0] mMon;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic sa, input logic sb, input logic sn, input logic [37:0] j);
      take_a  = sa;
      take_b  = sb;
      take_na = sn;
      jdo     = j;
      @(negedge clk);
      take_a  = 1'b0;
      take_b  = 1'b0;
      take_na = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [37:0] jdoAddr(input logic [7:0] a, input logic rd);
      logic [37:0] r;
      r        = '0;
      r[24:17] = a;
      r[35]    = rd;
      return r;
   endfunction

   function automatic logic [37:0] jdoData(input logic [31:0] d);
      logic [37:0] r;
      r       = '0;
      r[34:3] = d;
      return r;
   endfunction

   // Memory-side responder: grant and read-valid either forced or random.
   always @(negedge clk) begin
      case (gntMode)
         0:       memIf.mem_gnt = 1'b0;
         1:       memIf.mem_gnt = 1'b1;
         default: memIf.mem_gnt = ($urandom_range(0, 2) == 0);
      endcase
      case (rvMode)
         0:       memIf.mem_rvalid = 1'b0;
         1:       memIf.mem_rvalid = 1'b1;
         default: memIf.mem_rvalid = ($urandom_range(0, 2) == 0);
      endcase
      memIf.mem_rdata = (rvMode == 2) ? $urandom : rdataFixed;
   end

   always @(posedge clk) begin
      if (reset_n && memIf.mem_req && memIf.mem_gnt) begin
         capQ.push_back('{we: memIf.mem_we, addr: memIf.mem_addr, wdata: memIf.mem_wdata});
      end
   end

   // Reference model: command queue, pointer and one outstanding transaction.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         mPtr      = '0;
         mWaitGnt  = 0;
         mWaitData = 0;
         mTimer    = 0;
         mCur      = '0;
         mErr      = 0;
         mMon      = '0;
      end else begin
         bit   popNow, enq, doPush, ovf, tmoHit;
         cmd_t c;
         popNow = !mWaitGnt && !mWaitData && (mq.size() != 0);
         enq    = 0;
         doPush = 0;
         ovf    = 0;
         tmoHit = 0;
         c      = '0;
         if (take_a) begin
            if (jdo[35]) begin
               enq = 1;
               c   = '{we: 1'b0, addr: jdo[24:17], wdata: 32'h0};
            end else begin
               mPtr = jdo[24:17];
            end
         end else if (take_b) begin
            enq = 1;
            c   = '{we: 1'b1, addr: mPtr, wdata: jdo[34:3]};
         end else if (take_na) begin
            enq = 1;
            c   = '{we: 1'b0, addr: mPtr, wdata: 32'h0};
         end
         if (enq) begin
            if (mq.size() == FIFO_DEPTH && !popNow) begin
               ovf = 1;
               if (take_a) mPtr = c.addr;
            end else begin
               doPush = 1;
               mPtr   = c.addr + 8'd1;
            end
         end
         if (mWaitGnt) begin
            if (memIf.mem_gnt) begin
               mWaitGnt  = 0;
               mWaitData = !mCur.we;
               mTimer    = 0;
            end else if (mTimer == TIMEOUT - 1) begin
               mWaitGnt = 0;
               tmoHit   = 1;
            end else begin
               mTimer++;
            end
         end else if (mWaitData) begin
            if (memIf.mem_rvalid) begin
               mMon      = memIf.mem_rdata;
               mWaitData = 0;
            end else if (mTimer == TIMEOUT - 1) begin
               mWaitData = 0;
               tmoHit    = 1;
            end else begin
               mTimer++;
            end
         end else if (popNow) begin
            mCur     = mq.pop_front();
            mWaitGnt = 1;
            mTimer   = 0;
         end
         if (doPush) mq.push_back(c);
         if (ovf || tmoHit) mErr = 1;
         else if (take_a) mErr = 0;
      end
   end

   always @(negedge clk) begin
      checkOutput("req", memIf.mem_req, mWaitGnt);
      checkOutput("we", memIf.mem_we, mCur.we);
      checkOutput("addr", memIf.mem_addr, mCur.addr);
      checkOutput("wdata", memIf.mem_wdata, mCur.wdata);
      checkOutput("count", cmd_count, mq.size());
      checkOutput("ready", monitor_ready, (mq.size() == 0) && !mWaitGnt && !mWaitData);
      checkOutput("error", monitor_error, mErr);
      checkOutput("mondreg", MonDReg, mMon);
   end

   initial begin
      int n;
      reset_n = 1'b0;
      take_a  = 1'b0;
      take_b  = 1'b0;
      take_na = 1'b0;
      jdo     = '0;
      idleCycles(2);
      checkOutput("rst_req", memIf.mem_req, 0);
      checkOutput("rst_ready", monitor_ready, 1);
      checkOutput("rst_error", monitor_error, 0);
      checkOutput("rst_count", cmd_count, 0);
      checkOutput("rst_mondreg", MonDReg, 0);
      reset_n = 1'b1;
      idleCycles(1);

      $display("[TB] scenario 1: three writes from 0x10");
      gntMode = 1;
      capQ.delete();
      applyStimulus(1, 0, 0, jdoAddr(8'h10, 0));
      applyStimulus(0, 1, 0, jdoData(32'hAAAA_0001));
      applyStimulus(0, 1, 0, jdoData(32'hBBBB_0002));
      applyStimulus(0, 1, 0, jdoData(32'hCCCC_0003));
      idleCycles(10);
      checkOutput("t1_n", capQ.size(), 3);
      checkOutput("t1_w0", capQ[0], {1'b1, 8'h10, 32'hAAAA_0001});
      checkOutput("t1_w1", capQ[1], {1'b1, 8'h11, 32'hBBBB_0002});
      checkOutput("t1_w2", capQ[2], {1'b1, 8'h12, 32'hCCCC_0003});
      checkOutput("t1_ready", monitor_ready, 1);

      $display("[TB] scenario 2: pointer wrap and read-back");
      capQ.delete();
      rvMode     = 1;
      rdataFixed = 32'hDEAD_BEEF;
      applyStimulus(1, 0, 0, jdoAddr(8'hFF, 0));
      applyStimulus(0, 1, 0, jdoData(32'h1234_5678));
      applyStimulus(0, 0, 1, '0);
      idleCycles(10);
      checkOutput("t2_n", capQ.size(), 2);
      checkOutput("t2_w", capQ[0], {1'b1, 8'hFF, 32'h1234_5678});
      checkOutput("t2_r", {capQ[1].we, capQ[1].addr}, {1'b0, 8'h00});
      checkOutput("t2_mon", MonDReg, 32'hDEAD_BEEF);
      rvMode = 0;

      $display("[TB] scenario 3: overflow with grant held low");
      gntMode = 0;
      applyStimulus(1, 0, 0, jdoAddr(8'h20, 0));
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, jdoData(32'h100 + i));
      checkOutput("t3_count", cmd_count, 4);
      checkOutput("t3_err", monitor_error, 1);
      applyStimulus(1, 0, 0, jdoAddr(8'h30, 0));
      checkOutput("t3_clr", monitor_error, 0);
      gntMode = 1;
      idleCycles(15);
      checkOutput("t3_drained", monitor_ready, 1);

      $display("[TB] scenario 4: grant timeout");
      gntMode = 0;
      applyStimulus(1, 0, 0, jdoAddr(8'h40, 0));
      applyStimulus(0, 1, 0, jdoData(32'h4444_0000));
      applyStimulus(0, 1, 0, jdoData(32'h4444_0001));
      n = 0;
      while (!memIf.mem_req && n < 20) begin @(negedge clk); n++; end
      checkOutput("t4_seen", memIf.mem_req, 1);
      n = 0;
      while (memIf.mem_req && n < 40) begin @(negedge clk); n++; end
      checkOutput("t4_cycles", n, TIMEOUT);
      checkOutput("t4_err", monitor_error, 1);
      n = 0;
      while (!memIf.mem_req && n < 20) begin @(negedge clk); n++; end
      checkOutput("t4_next", memIf.mem_addr, 8'h41);
      gntMode = 1;
      idleCycles(6);

      $display("[TB] scenario 5: read data never returns");
      rvMode = 0;
      applyStimulus(1, 0, 0, jdoAddr(8'h50, 1));
      idleCycles(30);
      checkOutput("t5_mon", MonDReg, 32'hDEAD_BEEF);
      checkOutput("t5_err", monitor_error, 1);
      checkOutput("t5_ready", monitor_ready, 1);

      $display("[TB] scenario 6: reset during a request");
      gntMode = 0;
      applyStimulus(1, 0, 0, jdoAddr(8'h60, 0));
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, jdoData(32'h600 + i));
      checkOutput("t6_count", cmd_count, 3);
      checkOutput("t6_req", memIf.mem_req, 1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("t6_reqdrop", memIf.mem_req, 0);
      checkOutput("t6_flush", cmd_count, 0);
      idleCycles(2);
      reset_n = 1'b1;
      idleCycles(1);
      checkOutput("t6_ready", monitor_ready, 1);

      $display("[TB] random traffic");
      gntMode = 2;
      rvMode  = 2;
      for (int i = 0; i < 2000; i++) begin
         logic [63:0] rnd;
         int          r;
         rnd = {$urandom, $urandom};
         r   = $urandom_range(0, 11);
         case (r)
            0:       applyStimulus(1, 0, 0, rnd[37:0]);
            1, 2:    applyStimulus(0, 1, 0, rnd[37:0]);
            3:       applyStimulus(0, 0, 1, rnd[37:0]);
            4:       applyStimulus(1, 1, 1, rnd[37:0]);
            5:       applyStimulus(0, 1, 1, rnd[37:0]);
            default: applyStimulus(0, 0, 0, rnd[37:0]);
         endcase
      end
      gntMode = 1;
      rvMode  = 1;
      idleCycles(20);
      checkOutput("final_ready", monitor_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
